// File: rtl/pin_frame_mux_pkg.sv
// rtl/pin_frame_mux_pkg.sv - shared frame geometry helpers and control-word bit indices
package pin_frame_mux_pkg;

    // Bit positions inside control word 0 (all active-low core strobes)
    localparam int M1_N    = 0;
    localparam int MREQ_N  = 1;
    localparam int IORQ_N  = 2;
    localparam int RD_N    = 3;
    localparam int WR_N    = 4;
    localparam int RFSH_N  = 5;
    localparam int HALT_N  = 6;
    localparam int BUSAK_N = 7;

    // Slots per frame: interleaved framing repeats word 0 before every other word
    function automatic int frame_len(input int num_words, input int interleave);
        return (interleave != 0) ? 2 * (num_words - 1) : num_words;
    endfunction

    // Slot counter width, never narrower than one bit
    function automatic int slot_width(input int fl);
        return (fl > 1) ? $clog2(fl) : 1;
    endfunction

    // Which core-side word is carried in a given slot
    function automatic int slot_word(input int s, input int interleave);
        if (interleave != 0)
            return ((s % 2) == 0) ? 0 : (s / 2 + 1);
        return s;
    endfunction

endpackage

// File: rtl/pin_frame_timer.sv
// rtl/pin_frame_timer.sv - tick/slot counters with frame position decodes
module pin_frame_timer #(
    parameter int FL       = 4,
    parameter int PRESCALE = 1,
    parameter int SW       = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [SW-1:0] o_slot,
    output logic          o_last_tick,
    output logic          o_frame_start,
    output logic          o_frame_end
);

    localparam int            TW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(PRESCALE - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(FL - 1);

    logic [TW-1:0] r_tick;
    logic [SW-1:0] r_slot;
    logic          w_last_tick;
    logic          w_frame_end;

    assign w_last_tick   = (r_tick == TICK_MAX);
    assign w_frame_end   = w_last_tick && (r_slot == SLOT_MAX);
    assign o_slot        = r_slot;
    assign o_last_tick   = w_last_tick;
    assign o_frame_end   = w_frame_end;
    assign o_frame_start = (r_tick == '0) && (r_slot == '0);

    // Advance tick every enabled cycle; step slot when the tick wraps
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick <= '0;
            r_slot <= '0;
        end else if (i_en) begin
            if (w_last_tick) begin
                r_tick <= '0;
                r_slot <= w_frame_end ? '0 : r_slot + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_frame_mux.sv
// rtl/pin_frame_mux.sv - time-division mux of core words onto a narrow pin bank
module pin_frame_mux
    import pin_frame_mux_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_WORDS  = 3,
    parameter int INTERLEAVE = 1,
    parameter int PRESCALE   = 1,
    parameter int DIN_SLOT   = 1,
    localparam int FL        = frame_len(NUM_WORDS, INTERLEAVE),
    localparam int SW        = slot_width(FL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_WORDS*WIDTH-1:0] words_in,
    output logic [WIDTH-1:0]           pins_out,
    output logic [SW-1:0]              slot,
    output logic                       frame_start,
    output logic                       cpu_ce,
    input  logic [WIDTH-1:0]           din_pins,
    output logic [WIDTH-1:0]           din_word,
    output logic                       din_valid
);

    if (WIDTH < 1 || NUM_WORDS < 2 || NUM_WORDS > 8 || PRESCALE < 1 || PRESCALE > 16 ||
        DIN_SLOT < 0 || DIN_SLOT > FL - 1) begin : g_param_err
        $error("pin_frame_mux: parameter out of range");
    end

    localparam logic [SW-1:0] DIN_SEL = SW'(DIN_SLOT);

    logic [NUM_WORDS*WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0]           r_pins;
    logic [WIDTH-1:0]           r_din;
    logic                       r_din_valid;
    logic [SW-1:0]              w_slot;
    logic [SW-1:0]              w_next_slot;
    logic [WIDTH-1:0]           w_next_word;
    logic                       w_last_tick;
    logic                       w_frame_start;
    logic                       w_frame_end;
    logic                       w_din_hit;

    pin_frame_timer #(
        .FL       (FL),
        .PRESCALE (PRESCALE),
        .SW       (SW)
    ) u_timer (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .o_slot        (w_slot),
        .o_last_tick   (w_last_tick),
        .o_frame_start (w_frame_start),
        .o_frame_end   (w_frame_end)
    );

    // Only consumed when the frame is not ending, so the wrap case never matters
    assign w_next_slot = w_slot + 1'b1;
    assign w_din_hit   = en && w_last_tick && (w_slot == DIN_SEL);

    // Pick the shadow word that belongs to the upcoming slot
    always_comb begin
        w_next_word = '0;
        for (int s = 0; s < FL; s++) begin
            if (w_next_slot == SW'(s))
                w_next_word = r_shadow[slot_word(s, INTERLEAVE)*WIDTH +: WIDTH];
        end
    end

    // Snapshot the core bus at frame end; slot 0 takes word 0 straight from the live bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_pins   <= '0;
        end else if (en && w_last_tick) begin
            if (w_frame_end) begin
                r_shadow <= words_in;
                r_pins   <= words_in[WIDTH-1:0];
            end else begin
                r_pins   <= w_next_word;
            end
        end
    end

    // Sample inbound pins at the end of the capture slot and flag it for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din       <= '0;
            r_din_valid <= 1'b0;
        end else begin
            r_din_valid <= w_din_hit;
            if (w_din_hit)
                r_din <= din_pins;
        end
    end

    assign pins_out    = r_pins;
    assign slot        = w_slot;
    assign frame_start = w_frame_start;
    assign cpu_ce      = en & w_frame_start;
    assign din_word    = r_din;
    assign din_valid   = r_din_valid;

endmodule

// File: tb/tb_pin_frame_mux.sv
// tb/tb_pin_frame_mux.sv - randomized bench with behavioural frame model for two configurations
module tb_pin_frame_mux;

    localparam int A_NW = 3, A_IL = 1, A_PS = 1, A_DS = 1, A_FL = 4;
    localparam int B_NW = 4, B_IL = 0, B_PS = 2, B_DS = 3, B_FL = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] a_words;
    logic [31:0] b_words;
    logic [7:0]  din_pins;

    logic [7:0]  a_pins, b_pins, a_dw, b_dw;
    logic [1:0]  a_slot, b_slot;
    logic        a_fs, b_fs, a_ce, b_ce, a_dv, b_dv;

    int          checks;
    int          failures;
    bit          chk_on;

    // Behavioural model state: frame position in cycles, the snapshot being shown
    int          a_pos, b_pos;
    logic [23:0] a_snap;
    logic [31:0] b_snap;
    logic [7:0]  a_din, b_din;
    logic        a_val, b_val;

    logic [7:0]  a_lit [24] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF7, 8'h34, 8'hF7, 8'h12,
                                8'hF7, 8'h34, 8'hF7, 8'h12, 8'hF7, 8'h34, 8'hF7, 8'h12,
                                8'hF7, 8'h34, 8'hF7, 8'h12, 8'hEF, 8'hCD, 8'hEF, 8'hAB};
    logic [7:0]  b_lit [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

    pin_frame_mux #(.WIDTH(8), .NUM_WORDS(A_NW), .INTERLEAVE(A_IL), .PRESCALE(A_PS), .DIN_SLOT(A_DS)) u_a (
        .clk(clk), .rst(rst), .en(en), .words_in(a_words), .pins_out(a_pins), .slot(a_slot),
        .frame_start(a_fs), .cpu_ce(a_ce), .din_pins(din_pins), .din_word(a_dw), .din_valid(a_dv));

    pin_frame_mux #(.WIDTH(8), .NUM_WORDS(B_NW), .INTERLEAVE(B_IL), .PRESCALE(B_PS), .DIN_SLOT(B_DS)) u_b (
        .clk(clk), .rst(rst), .en(en), .words_in(b_words), .pins_out(b_pins), .slot(b_slot),
        .frame_start(b_fs), .cpu_ce(b_ce), .din_pins(din_pins), .din_word(b_dw), .din_valid(b_dv));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int word_of(input int s, input int il);
        if (il != 0) return ((s % 2) == 0) ? 0 : (s / 2 + 1);
        return s;
    endfunction

    // Reference model: a frame is FL*PS enabled cycles; the snapshot is replaced at its last cycle
    always @(posedge clk) begin
        if (rst) begin
            a_pos <= 0; a_snap <= '0; a_din <= '0; a_val <= 1'b0;
            b_pos <= 0; b_snap <= '0; b_din <= '0; b_val <= 1'b0;
        end else begin
            a_val <= en && (a_pos == A_DS * A_PS + A_PS - 1);
            b_val <= en && (b_pos == B_DS * B_PS + B_PS - 1);
            if (en) begin
                if (a_pos == A_DS * A_PS + A_PS - 1) a_din <= din_pins;
                if (b_pos == B_DS * B_PS + B_PS - 1) b_din <= din_pins;
                if (a_pos == A_FL * A_PS - 1) a_snap <= a_words;
                if (b_pos == B_FL * B_PS - 1) b_snap <= b_words;
                a_pos <= (a_pos + 1) % (A_FL * A_PS);
                b_pos <= (b_pos + 1) % (B_FL * B_PS);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_pins", 32'(a_pins), 32'(a_snap[word_of(a_pos / A_PS, A_IL)*8 +: 8]));
        chk("a_slot", 32'(a_slot), 32'(a_pos / A_PS));
        chk("a_frame_start", 32'(a_fs), 32'(a_pos == 0));
        chk("a_cpu_ce", 32'(a_ce), 32'(en && a_pos == 0));
        chk("a_din_word", 32'(a_dw), 32'(a_din));
        chk("a_din_valid", 32'(a_dv), 32'(a_val));
        chk("b_pins", 32'(b_pins), 32'(b_snap[word_of(b_pos / B_PS, B_IL)*8 +: 8]));
        chk("b_slot", 32'(b_slot), 32'(b_pos / B_PS));
        chk("b_frame_start", 32'(b_fs), 32'(b_pos == 0));
        chk("b_cpu_ce", 32'(b_ce), 32'(en && b_pos == 0));
        chk("b_din_word", 32'(b_dw), 32'(b_din));
        chk("b_din_valid", 32'(b_dv), 32'(b_val));
    endtask

    task automatic sample();
        @(negedge clk);
        if (chk_on) compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_on   = 1'b0;
        rst      = 1'b1;
        en       = 1'b1;
        a_words  = 24'h1234F7;
        b_words  = 32'h44332211;
        din_pins = 8'h00;
        sample(); advance();
        sample(); advance();
        rst    = 1'b0;
        chk_on = 1'b1;

        // Defaults, prescaled linear framing, data capture and coherency
        for (int i = 0; i < 24; i++) begin
            din_pins = ((i % 4) == 1) ? 8'h5A : 8'h00;
            if (i == 18) a_words = 24'hABCDEF;
            sample();
            if (i == 0) begin
                chk("lit_reset_slot", 32'(a_slot), 32'd0);
                chk("lit_reset_pins", 32'(a_pins), 32'h00);
                chk("lit_reset_din_word", 32'(a_dw), 32'h00);
                chk("lit_reset_cpu_ce", 32'(a_ce), 32'd1);
            end
            chk("lit_a_pins", 32'(a_pins), 32'(a_lit[i]));
            chk("lit_a_cpu_ce", 32'(a_ce), 32'((i % 4) == 0));
            chk("lit_a_din_valid", 32'(a_dv), 32'((i % 4) == 2));
            chk("lit_a_din_word", 32'(a_dw), (i >= 2) ? 32'h5A : 32'h00);
            if (i < 16) begin
                chk("lit_b_pins", 32'(b_pins), 32'(b_lit[i]));
                chk("lit_b_cpu_ce", 32'(b_ce), 32'((i % 8) == 0));
            end
            advance();
        end

        // Reach slot 2, then hold en low for 5 cycles
        din_pins = 8'h00;
        for (int i = 0; i < 2; i++) begin
            sample(); advance();
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("lit_hold_slot", 32'(a_slot), 32'd2);
            chk("lit_hold_pins", 32'(a_pins), 32'hEF);
            chk("lit_hold_cpu_ce", 32'(a_ce), 32'd0);
            if (i > 0) chk("lit_hold_din_valid", 32'(a_dv), 32'd0);
            advance();
        end
        en = 1'b1;
        sample();
        chk("lit_resume_slot", 32'(a_slot), 32'd2);
        advance();
        rst = 1'b1;
        sample();
        chk("lit_pre_reset_slot", 32'(a_slot), 32'd3);
        chk("lit_pre_reset_pins", 32'(a_pins), 32'hAB);
        advance();
        rst = 1'b0;
        sample();
        chk("lit_post_reset_slot", 32'(a_slot), 32'd0);
        chk("lit_post_reset_pins", 32'(a_pins), 32'h00);
        chk("lit_post_reset_din_word", 32'(a_dw), 32'h00);
        chk("lit_post_reset_cpu_ce", 32'(a_ce), 32'd1);
        chk("lit_post_reset_b_pins", 32'(b_pins), 32'h00);
        advance();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            rst      = ($urandom_range(0, 199) == 0);
            din_pins = 8'($urandom);
            if ($urandom_range(0, 15) == 0) a_words = 24'($urandom);
            if ($urandom_range(0, 15) == 0) b_words = $urandom;
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pin_frame_mux.md
Name: pin_frame_mux

Overview:
- Time-division multiplexer that carries a wide core-side bus (control word plus address words) out through a narrow bank of output pins.
- Also generates the core clock enable and samples the inbound data pins.
- Parametrised successor to the fixed 4-phase control/addr-lo/control/addr-hi scheme. Adds:
  - configurable word width and word count;
  - interleaved or linear framing;
  - a phase prescaler;
  - coherent per-frame snapshots;
  - data-in capture with a valid strobe.
- Sits between the top-level pin wrapper and the CPU core.

Parameters:
- WIDTH, 8: bits per word and per pin bank.
- NUM_WORDS, 3: words in words_in; word 0 is the control word. Legal range 2..8.
- INTERLEAVE, 1: 1 = emit word 0 before every other word; 0 = emit words in order 0..NUM_WORDS-1.
- PRESCALE, 1: clk cycles per slot. Legal range 1..16.
- DIN_SLOT, 1: slot at whose last tick din_pins is sampled. Legal range 0..FL-1.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: global advance enable. When low, all state holds.
- words_in, input, NUM_WORDS*WIDTH: core-side words. Word k occupies bits [k*WIDTH +: WIDTH].
- pins_out, output, WIDTH: registered multiplexed word driven to the pins.
- slot, output, clog2(FL): current slot index.
- frame_start, output, 1: high during tick 0 of slot 0.
- cpu_ce, output, 1: one-cycle core clock enable per frame.
- din_pins, input, WIDTH: inbound data pins.
- din_word, output, WIDTH: last sampled data word.
- din_valid, output, 1: one-cycle pulse when din_word updates.

Behaviour:
- Frame length: FL = INTERLEAVE ? 2*(NUM_WORDS-1) : NUM_WORDS. Frame period is FL*PRESCALE cycles.
- Slot-to-word map:
  - INTERLEAVE=1: slot 2j maps to word 0; slot 2j+1 maps to word j+1.
  - INTERLEAVE=0: slot s maps to word s.
- Counters:
  - tick counts 0..PRESCALE-1.
  - slot increments when tick wraps, and wraps from FL-1 to 0.
  - Both counters advance only when en=1.
- Derived strobes:
  - last_tick = (tick == PRESCALE-1).
  - frame_end = last_tick and slot == FL-1.
- Shadow register:
  - Holds NUM_WORDS*WIDTH bits.
  - Loads words_in on the frame_end edge when en=1, so the whole frame emitted next is one coherent snapshot.
- pins_out:
  - On every last_tick edge with en=1, loads the shadow word for the next slot.
  - On frame_end, loads word 0 taken directly from words_in. This is the same value written into the shadow on that edge.
  - Result: pins_out always shows the word for the current slot.
- cpu_ce:
  - Combinational: en and frame_start.
  - The core advances at the end of the first cycle of each frame and has FL*PRESCALE-1 cycles to settle before the next snapshot.
- din_word and din_valid:
  - On the edge ending the last tick of slot DIN_SLOT with en=1, din_word <= din_pins.
  - din_valid is registered and high for exactly the following cycle.
- en low:
  - Counters, shadow, pins_out and din_word hold.
  - cpu_ce = 0; din_valid clears next cycle.
  - frame_start still decodes from the held state, but is gated by en in cpu_ce.
- Reset (synchronous, active-high):
  - tick = 0, slot = 0, shadow = 0, pins_out = 0, din_word = 0, din_valid = 0.
  - The first cycle after reset with en=1 is a frame start, so cpu_ce = 1.
  - pins_out shows 0 for the whole first frame.
  - Reset mid-frame aborts the frame immediately; no partial-capture side effects.
- Simultaneous events:
  - If DIN_SLOT == FL-1, din capture and shadow capture occur on the same edge; both are performed.
  - With PRESCALE=1, every cycle is a last_tick.
- Width rule: slot width is max(1, clog2(FL)). Out-of-range parameters are an elaboration error.

Decomposition:
- Shared package holds:
  - FL and slot-width functions;
  - a slot-to-word-index function (used by RTL and bench);
  - the control-word bit index constants: M1_N=0, MREQ_N=1, IORQ_N=2, RD_N=3, WR_N=4, RFSH_N=5, HALT_N=6, BUSAK_N=7.
- One natural sub-module, pin_frame_timer: the tick/slot counters and the frame_start, last_tick and frame_end decodes.
- The mux, shadow and din capture stay in the parent.

Test Plan:
- Defaults. Hold words_in = {A_hi=8'h12, A_lo=8'h34, ctrl=8'hF7}, en=1, after reset.
  - Frame 1: pins_out = 00,00,00,00.
  - Frame 2 onward: pins_out repeats F7,34,F7,12.
  - cpu_ce high once every 4 cycles, coincident with slot=0.
- INTERLEAVE=0, NUM_WORDS=4, PRESCALE=2, words {44,33,22,11}.
  - pins_out sequence: 11,11,22,22,33,33,44,44.
  - cpu_ce period 8.
- Coherency. Change words_in from {12,34,F7} to {AB,CD,EF} in slot 2.
  - The current frame keeps F7,34,F7,12.
  - The next frame shows EF,CD,EF,AB.
- Data in. DIN_SLOT=1, din_pins = 8'h5A only during slot 1.
  - din_word = 5A.
  - din_valid pulses once, the cycle after slot 1 ends, once per frame.
- en gating. Drop en for 5 cycles mid-slot 2.
  - slot and pins_out frozen; cpu_ce = 0; din_valid low.
  - The sequence resumes exactly where it stopped.
- Reset in slot 3 with rst=1 for 1 cycle.
  - Next cycle: slot=0, pins_out=00, din_word=00.
  - cpu_ce=1 if en=1.
